seq_divider: RTL and testbench

Sequential unsigned restoring divider: the inverse operation of the team's 8x8 segmented multiplier datapath. It accepts a 16-bit dividend and an 8-bit divisor over a valid/ready handshake and produces quotient and remainder one bit per clock. It sits beside the multiplier, so that exact and approximate products can be divided back to check their error and to reconstruct operands.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 104 ++++++++++
 tb/tb_seq_divider.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
// Imported by the divider top and its restoring-step slice.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIVIDEND_W_DEF = 16;
  localparam int DIVISOR_W_DEF  = 8;

  // Bits needed to count DIVIDEND_W-1 down to zero; never below 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Shift in a dividend bit, compare, conditionally subtract.
module div_step
  import div_pkg::*;
#(
  parameter int DW = DIVISOR_W_DEF
) (
  input  logic [DW:0]   i_rem,
  input  logic          i_bit,
  input  logic [DW-1:0] i_divisor,
  output logic [DW:0]   o_rem,
  output logic          o_q
);

  logic [DW:0] w_shift;
  logic [DW:0] w_div_ext;
  logic        w_ge;
  logic        w_unused;

  // Top bit is always zero on entry since rem < divisor.
  assign w_unused  = i_rem[DW];
  assign w_shift   = {i_rem[DW-1:0], i_bit};
  assign w_div_ext = {1'b0, i_divisor};
  assign w_ge      = (w_shift >= w_div_ext);

  assign o_q   = w_ge;
  assign o_rem = w_ge ? (w_shift - w_div_ext) : w_shift;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Valid/ready on both sides; results held in DONE until accepted.
module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CW = clog2(DIVIDEND_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDEND_W - 1);

  div_state_t            r_state;
  logic [DIVIDEND_W-1:0] r_dsh;
  logic [DIVISOR_W-1:0]  r_div;
  logic [DIVISOR_W:0]    r_rem;
  logic [CW-1:0]         r_cnt;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W-1:0]  r_r;
  logic                  r_dbz;

  logic [DIVISOR_W:0]    w_rem_nxt;
  logic                  w_qbit;
  logic [DIVIDEND_W-1:0] w_dsh_nxt;

  div_step #(
    .DW(DIVISOR_W)
  ) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_dsh[DIVIDEND_W-1]),
    .i_divisor(r_div),
    .o_rem    (w_rem_nxt),
    .o_q      (w_qbit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign w_dsh_nxt = {r_dsh[DIVIDEND_W-2:0], w_qbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dsh   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dsh <= dividend;
            r_div <= divisor;
            r_rem <= '0;
            r_cnt <= CNT_LAST;
            if (divisor == '0) begin
              r_q     <= '1;
              r_r     <= dividend[DIVISOR_W-1:0];
              r_dbz   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_dsh <= w_dsh_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_q     <= w_dsh_nxt;
            r_r     <= w_rem_nxt[DIVISOR_W-1:0];
            r_dbz   <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed cases, back-pressure,
// mid-operation reset and random operands against a / and % model.
module tb_seq_divider;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int   checks;
  int   errors;
  exp_t sb[$];

  seq_divider #(
    .DIVIDEND_W(16),
    .DIVISOR_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a,
                                 input logic [7:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = a[7:0];
      e.dbz = 1'b1;
    end else begin
      e.q   = a / {8'd0, b};
      e.r   = 8'(a % {8'd0, b});
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // hold: cycles to stall out_ready in DONE while offering other operands
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        input int hold);
    int   n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), (b == 8'd0) ? 0 : 16);
    chk("in_ready_done", 32'(in_ready), 0);
    e = sb.pop_front();
    chk("quotient", 32'(quotient), 32'(e.q));
    chk("remainder", 32'(remainder), 32'(e.r));
    chk("dbz", 32'(div_by_zero), 32'(e.dbz));
    if (e.b != 8'd0) begin
      chk("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder),
          32'(e.a));
      chk("rem_lt_div", 32'(remainder < e.b), 1);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = 16'h1234 + 16'(i);
      divisor  = 8'd3;
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_ready", 32'(in_ready), 0);
      chk("hold_q", 32'(quotient), 32'(e.q));
      chk("hold_r", 32'(remainder), 32'(e.r));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 0);
    chk("post_hs_ready", 32'(in_ready), 1);
  endtask

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_q", 32'(quotient), 0);
    chk("rst_r", 32'(remainder), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);
    rst = 1'b0;

    run_op(16'd1000, 8'd7, 0);
    run_op(16'hFFFF, 8'd1, 0);
    run_op(16'd34600, 8'd173, 0);
    run_op(16'd5, 8'd0, 0);
    run_op(16'd9, 8'd3, 0);
    run_op(16'd50000, 8'd255, 5);
    run_op(16'h1238, 8'd3, 0);

    // abort an operation partway through CALC
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_q", 32'(quotient), 0);
    chk("abort_r", 32'(remainder), 0);
    chk("abort_dbz", 32'(div_by_zero), 0);
    n = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    chk("abort_no_pulse", 32'(n), 0);
    run_op(16'd100, 8'd10, 0);

    for (int k = 0; k < 2000; k++) begin
      run_op(16'($urandom), 8'($urandom), 0);
    end

    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
